// File: rtl/reversi_pkg.sv
// Shared definitions for the Reversi move scanner.
//   - cell encoding constants (2'b0x is empty, 2'b10 white, 2'b11 black)
//   - direction enum and the dx/dy step lookups
//   - cell_at(): extracts one 2-bit cell from the 128-bit board vector
//   - FSM state type and state constants
package reversi_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_WHITE = 2'b10;
  localparam logic [1:0] CELL_BLACK = 2'b11;

  typedef enum logic [2:0] {
    DIR_UP    = 3'd0,
    DIR_DOWN  = 3'd1,
    DIR_LEFT  = 3'd2,
    DIR_RIGHT = 3'd3,
    DIR_LT    = 3'd4,
    DIR_LB    = 3'd5,
    DIR_RT    = 3'd6,
    DIR_RB    = 3'd7
  } dir_e;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ORIGIN = 2'd1;
  localparam state_t ST_WALK   = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  function automatic logic signed [3:0] dx(input logic [2:0] d);
    case (d)
      DIR_LEFT, DIR_LT, DIR_LB:  dx = -4'sd1;
      DIR_RIGHT, DIR_RT, DIR_RB: dx = 4'sd1;
      default:                   dx = 4'sd0;
    endcase
  endfunction

  function automatic logic signed [3:0] dy(input logic [2:0] d);
    case (d)
      DIR_UP, DIR_LT, DIR_RT:   dy = -4'sd1;
      DIR_DOWN, DIR_LB, DIR_RB: dy = 4'sd1;
      default:                  dy = 4'sd0;
    endcase
  endfunction

  // Cell (cx, cy) sits at bit offset 2*(8*cx+cy) = {cx, cy, 1'b0}.
  function automatic logic [1:0] cell_at(input logic [127:0] b,
                                         input logic [2:0]   cx,
                                         input logic [2:0]   cy);
    cell_at = b[{cx, cy, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/dir_stepper.sv
// Combinational one-cell step of the scan cursor.
// Ports:
//   cur_x_i, cur_y_i  signed 4-bit cursor (always on-board when used)
//   dir_i             direction index 0..7
//   nxt_x_o, nxt_y_o  cursor moved one cell along dir_i
//   off_o             moved cursor lies outside the 8x8 board
module dir_stepper
  import reversi_pkg::*;
(
  input  logic signed [3:0] cur_x_i,
  input  logic signed [3:0] cur_y_i,
  input  logic [2:0]        dir_i,
  output logic signed [3:0] nxt_x_o,
  output logic signed [3:0] nxt_y_o,
  output logic              off_o
);

  assign nxt_x_o = cur_x_i + dx(dir_i);
  assign nxt_y_o = cur_y_i + dy(dir_i);

  // Inputs are in 0..7, so results are in -1..8; 8 wraps to -8 in 4-bit
  // signed, which makes the sign bit a complete off-board test.
  assign off_o = nxt_x_o[3] | nxt_y_o[3];

endmodule

// File: rtl/move_scan_ctrl.sv
// Reversi legal-move scanner. Snapshots the board on an accepted start,
// walks the eight directions from the origin one cell per cycle and reports
// which directions capture, whether the move is legal and (optionally) the
// 64-cell flip mask.
// Ports:
//   clk           rising-edge clock
//   resetn        synchronous reset, ACTIVE-HIGH despite its name
//   start         scan request, accepted only while idle
//   x, y          origin column / row
//   player_black  1 = black to move
//   board         128-bit board, cell (cx,cy) at bits [2*(8*cx+cy) +: 2]
//   busy          scan in progress (ORIGIN, WALK, DONE)
//   done          one-cycle pulse, results final
//   legal         OR of dir_mask
//   dir_mask      bit d = direction d captures
//   flip_mask     bit 8*cx+cy = disc to flip
// Build option: define MOVE_SCAN_FLIP_EN to build the flip-mask logic;
// without it flip_mask is tied to 0 and timing is unchanged.
module move_scan_ctrl
  import reversi_pkg::*;
#(
  parameter int BOARD_W   = 8,
  parameter int CELL_BITS = 2
)
(
  input  logic                                 clk,
  input  logic                                 resetn,
  input  logic                                 start,
  input  logic [2:0]                           x,
  input  logic [2:0]                           y,
  input  logic                                 player_black,
  input  logic [BOARD_W*BOARD_W*CELL_BITS-1:0] board,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 legal,
  output logic [7:0]                           dir_mask,
  output logic [BOARD_W*BOARD_W-1:0]           flip_mask
);

  state_t                              state_q, state_d;
  logic [BOARD_W*BOARD_W*CELL_BITS-1:0] board_q;
  logic [2:0]                          org_x_q, org_y_q;
  logic                                pb_q;
  logic [2:0]                          dir_q, dir_d;
  logic signed [3:0]                   cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic                                off_q, off_d;
  logic [2:0]                          run_q, run_d;
  logic [7:0]                          dir_mask_q, dir_mask_d;

  logic [1:0]        cur_cell, org_cell;
  logic              is_opp, is_own;
  logic              accept;
  logic              step_cont;
  logic signed [3:0] st_x, st_y, nxt_x, nxt_y;
  logic [2:0]        st_dir;
  logic              nxt_off;

  assign accept   = (state_q == ST_IDLE) && start;
  assign cur_cell = cell_at(board_q, cur_x_q[2:0], cur_y_q[2:0]);
  assign org_cell = cell_at(board_q, org_x_q, org_y_q);
  assign is_opp   = !off_q && (cur_cell == (pb_q ? CELL_WHITE : CELL_BLACK));
  assign is_own   = !off_q && (cur_cell == (pb_q ? CELL_BLACK : CELL_WHITE));

  // Single stepper: advance the cursor while a run of opponent discs
  // continues, otherwise start the next direction from the origin.
  assign step_cont = (state_q == ST_WALK) && is_opp;
  assign st_x      = step_cont ? cur_x_q : $signed({1'b0, org_x_q});
  assign st_y      = step_cont ? cur_y_q : $signed({1'b0, org_y_q});
  assign st_dir    = (state_q != ST_WALK) ? 3'd0 :
                     (is_opp ? dir_q : dir_q + 3'd1);

  dir_stepper u_step (
    .cur_x_i (st_x),
    .cur_y_i (st_y),
    .dir_i   (st_dir),
    .nxt_x_o (nxt_x),
    .nxt_y_o (nxt_y),
    .off_o   (nxt_off)
  );

`ifdef MOVE_SCAN_FLIP_EN
  logic [63:0] pend_q, pend_d;
  logic [63:0] flip_q, flip_d;
  logic [5:0]  cur_idx;
  assign cur_idx = {cur_x_q[2:0], cur_y_q[2:0]};
`endif

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    off_d      = off_q;
    run_d      = run_q;
    dir_mask_d = dir_mask_q;
`ifdef MOVE_SCAN_FLIP_EN
    pend_d     = pend_q;
    flip_d     = flip_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ORIGIN;
          dir_mask_d = '0;
`ifdef MOVE_SCAN_FLIP_EN
          flip_d     = '0;
`endif
        end
      end
      ST_ORIGIN: begin
        if (org_cell[1]) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WALK;
          dir_d   = 3'd0;
          cur_x_d = nxt_x;
          cur_y_d = nxt_y;
          off_d   = nxt_off;
          run_d   = 3'd0;
`ifdef MOVE_SCAN_FLIP_EN
          pend_d  = '0;
`endif
        end
      end
      ST_WALK: begin
        if (is_opp) begin
          run_d   = (run_q == 3'd6) ? 3'd6 : run_q + 3'd1;
          cur_x_d = nxt_x;
          cur_y_d = nxt_y;
          off_d   = nxt_off;
`ifdef MOVE_SCAN_FLIP_EN
          pend_d[cur_idx] = 1'b1;
`endif
        end else begin
          // Off-board, empty or own disc ends this direction.
          if (is_own && (run_q != 3'd0)) begin
            dir_mask_d[dir_q] = 1'b1;
`ifdef MOVE_SCAN_FLIP_EN
            flip_d = flip_q | pend_q;
`endif
          end
          if (dir_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            dir_d   = dir_q + 3'd1;
            cur_x_d = nxt_x;
            cur_y_d = nxt_y;
            off_d   = nxt_off;
            run_d   = 3'd0;
`ifdef MOVE_SCAN_FLIP_EN
            pend_d  = '0;
`endif
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q    <= ST_IDLE;
      dir_q      <= 3'd0;
      dir_mask_q <= '0;
`ifdef MOVE_SCAN_FLIP_EN
      flip_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      dir_mask_q <= dir_mask_d;
`ifdef MOVE_SCAN_FLIP_EN
      flip_q     <= flip_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      board_q <= board;
      org_x_q <= x;
      org_y_q <= y;
      pb_q    <= player_black;
    end
    cur_x_q <= cur_x_d;
    cur_y_q <= cur_y_d;
    off_q   <= off_d;
    run_q   <= run_d;
`ifdef MOVE_SCAN_FLIP_EN
    pend_q  <= pend_d;
`endif
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  // An occupied origin skips the walk, so the mask is already zero there.
  assign legal    = |dir_mask_q;
  assign dir_mask = dir_mask_q;
`ifdef MOVE_SCAN_FLIP_EN
  assign flip_mask = flip_q;
`else
  assign flip_mask = '0;
`endif

endmodule

// File: tb/tb_move_scan_ctrl.sv
module tb_move_scan_ctrl;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [2:0]   x, y;
  logic         player_black;
  logic [127:0] board;
  logic         busy, done, legal;
  logic [7:0]   dir_mask;
  logic [63:0]  flip_mask;

  move_scan_ctrl dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .x            (x),
    .y            (y),
    .player_black (player_black),
    .board        (board),
    .busy         (busy),
    .done         (done),
    .legal        (legal),
    .dir_mask     (dir_mask),
    .flip_mask    (flip_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int ndone = 0;
  int last_lat = -1;

  typedef struct {
    logic [7:0]  dm;
    logic [63:0] fm;
    int          lat;
    int          t0;
  } exp_t;
  exp_t sbq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] put(input logic [127:0] b, input int cx, input int cy,
                                       input logic [1:0] v);
    b[2*(8*cx+cy) +: 2] = v;
    return b;
  endfunction

  // Reference scan: straightforward direction-by-direction walk.
  function automatic void ref_scan(input logic [127:0] b, input int ox, input int oy,
                                   input logic pb, output logic [7:0] dm,
                                   output logic [63:0] fm, output int lat);
    int ddx[8] = '{0, 0, -1, 1, -1, -1, 1, 1};
    int ddy[8] = '{-1, 1, 0, 0, -1, 1, -1, 1};
    dm = '0; fm = '0; lat = 2;
    if (b[2*(8*ox+oy)+1]) return;
    for (int d = 0; d < 8; d++) begin
      int cx, cy, run, n;
      logic [63:0] pend;
      logic ok;
      logic [1:0] c;
      cx = ox + ddx[d]; cy = oy + ddy[d]; run = 0; n = 0; pend = '0; ok = 1'b0;
      forever begin
        n++;
        if (cx < 0 || cx > 7 || cy < 0 || cy > 7) break;
        c = b[2*(8*cx+cy) +: 2];
        if (!c[1]) break;
        if (c[0] == pb) begin ok = (run > 0); break; end
        run++;
        pend[8*cx+cy] = 1'b1;
        cx += ddx[d]; cy += ddy[d];
      end
      lat += n;
      if (ok) begin dm[d] = 1'b1; fm |= pend; end
    end
  endfunction

  task automatic push_exp(input logic [127:0] b, input int ox, input int oy,
                          input logic pb, input int t0);
    exp_t e;
    ref_scan(b, ox, oy, pb, e.dm, e.fm, e.lat);
`ifndef MOVE_SCAN_FLIP_EN
    e.fm = '0;
`endif
    e.t0 = t0;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done) begin
      ndone++;
      if (sbq.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        last_lat = cyc - e.t0;
        chk("latency", 64'(last_lat), 64'(e.lat));
        chk("dir_mask", 64'(dir_mask), 64'(e.dm));
        chk("legal", 64'(legal), 64'(|e.dm));
        chk("flip_mask", flip_mask, e.fm);
        chk("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int lim = 0;
    while (sbq.size() != 0 && lim < 100) begin
      @(negedge clk);
      lim++;
    end
    if (sbq.size() != 0) begin
      chk(tag, 64'd0, 64'd1);
      sbq.delete();
    end
  endtask

  task automatic run_scan(input logic [127:0] b, input int ox, input int oy, input logic pb);
    int t0;
    @(negedge clk);
    board = b; x = 3'(ox); y = 3'(oy); player_black = pb; start = 1'b1;
    t0 = cyc;
    push_exp(b, ox, oy, pb, t0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 64'(busy), 64'd1);
    // Scramble inputs after acceptance; the snapshot must be used.
    board = {$urandom, $urandom, $urandom, $urandom};
    x = 3'($urandom); y = 3'($urandom); player_black = ~pb;
    drain("done_timeout");
  endtask

  task automatic held_start(input int nscans);
    int t0, lat;
    logic [127:0] b;
    b = '0;
    b = put(b, 3, 3, 2'b10); b = put(b, 4, 4, 2'b10);
    b = put(b, 3, 4, 2'b11); b = put(b, 4, 3, 2'b11);
    @(negedge clk);
    board = b; x = 3'd2; y = 3'd3; player_black = 1'b1; start = 1'b1;
    t0 = cyc;
    push_exp(b, 2, 3, 1'b1, t0);
    lat = sbq[$].lat;
    for (int k = 1; k < nscans; k++) begin
      wait_until(t0 + 2);
      b = put({$urandom, $urandom, $urandom, $urandom}, 2, 3, 2'b00);
      board = b;
      wait_until(t0 + lat + 1);
      t0 = t0 + lat + 1;
      push_exp(b, 2, 3, 1'b1, t0);
      lat = sbq[$].lat;
    end
    wait_until(t0 + 1);
    start = 1'b0;
    drain("held_timeout");
  endtask

  initial begin
    logic [127:0] b;
    int t0, d0;

    resetn = 1'b1; start = 1'b0; x = '0; y = '0; player_black = 1'b0; board = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_legal", 64'(legal), 64'd0);
    chk("rst_dir_mask", 64'(dir_mask), 64'd0);
    chk("rst_flip_mask", flip_mask, 64'd0);
    resetn = 1'b0;

    // Opening position, black at (2,3).
    b = '0;
    b = put(b, 3, 3, 2'b10); b = put(b, 4, 4, 2'b10);
    b = put(b, 3, 4, 2'b11); b = put(b, 4, 3, 2'b11);
    run_scan(b, 2, 3, 1'b1);
    chk("open_lat", 64'(last_lat), 64'd11);
    chk("open_dm", 64'(dir_mask), 64'h08);
    chk("open_legal", 64'(legal), 64'd1);
`ifdef MOVE_SCAN_FLIP_EN
    chk("open_flip", flip_mask, 64'h1 << 27);
`else
    chk("open_flip_tied", flip_mask, 64'd0);
`endif
    repeat (2) @(negedge clk);
    chk("open_hold_dm", 64'(dir_mask), 64'h08);

    // Occupied origin.
    run_scan(b, 3, 3, 1'b1);
    chk("occ_lat", 64'(last_lat), 64'd2);
    chk("occ_legal", 64'(legal), 64'd0);
    chk("occ_dm", 64'(dir_mask), 64'd0);

    // Corner of an empty board.
    run_scan('0, 0, 0, 1'b0);
    chk("corner_lat", 64'(last_lat), 64'd10);
    chk("corner_legal", 64'(legal), 64'd0);

    // Row 0 = W B B B B B B _, white plays (7,0); 2'b01 cells count as empty.
    b = {64{2'b01}};
    b = put(b, 0, 0, 2'b10);
    for (int i = 1; i <= 6; i++) b = put(b, i, 0, 2'b11);
    b = put(b, 7, 0, 2'b00);
    run_scan(b, 7, 0, 1'b0);
    chk("row_dm", 64'(dir_mask), 64'h04);
`ifdef MOVE_SCAN_FLIP_EN
    chk("row_flip", flip_mask, 64'h0001_0101_0101_0100);
`endif

    // Random boards and origins.
    for (int i = 0; i < 10; i++) begin
      int ox, oy;
      ox = $urandom_range(0, 7); oy = $urandom_range(0, 7);
      b = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) != 0) b = put(b, ox, oy, 2'b00);
      run_scan(b, ox, oy, 1'($urandom));
    end

    // Reset mid-scan: up direction captures early, reset in cycle 5.
    b = '0;
    b = put(b, 3, 6, 2'b10); b = put(b, 3, 5, 2'b11);
    @(negedge clk);
    board = b; x = 3'd3; y = 3'd7; player_black = 1'b1; start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_until(t0 + 5);
    chk("pre_rst_dm", 64'(dir_mask), 64'h01);
    resetn = 1'b1;
    d0 = ndone;
    wait_until(t0 + 6);
    resetn = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_legal", 64'(legal), 64'd0);
    chk("abort_dm", 64'(dir_mask), 64'd0);
    chk("abort_flip", flip_mask, 64'd0);
    repeat (60) @(negedge clk);
    chk("abort_no_done", 64'(ndone - d0), 64'd0);
    run_scan(b, 3, 7, 1'b1);
    chk("after_abort_dm", 64'(dir_mask), 64'h01);

    // start together with reset is dropped.
    @(negedge clk);
    start = 1'b1; resetn = 1'b1;
    @(negedge clk);
    start = 1'b0; resetn = 1'b0;
    chk("rst_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("rst_start_busy2", 64'(busy), 64'd0);

    // start held high, board changed mid-scan.
    held_start(4);

    repeat (5) @(negedge clk);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
